// File: rtl/servo_frame_decoder_pkg.sv
// Shared definitions for the servo frame decoder.
//   PAYLOAD_BITS       - width of one received byte
//   DEFAULT_TERMINATOR - end-of-frame byte used unless overridden
//   DIVIDEND_W         - width of the nanosecond dividend (max 255_255_255)
//   WIDTH_W            - width of the pulse-width quotient (max 6_898_790)
//   state_e            - frame FSM encodings
//   calc_dividend      - b0*1e6 + b1*1e3 + b2, in nanoseconds
package servo_frame_decoder_pkg;

    localparam int unsigned PAYLOAD_BITS = 8;
    localparam logic [PAYLOAD_BITS-1:0] DEFAULT_TERMINATOR = 8'h0A;
    localparam int unsigned DIVIDEND_W = 28;
    localparam int unsigned WIDTH_W = 23;

    typedef enum logic [2:0] {
        StB0   = 3'd0,
        StB1   = 3'd1,
        StB2   = 3'd2,
        StTerm = 3'd3,
        StCalc = 3'd4
    } state_e;

    function automatic logic [DIVIDEND_W-1:0] calc_dividend(
        input logic [PAYLOAD_BITS-1:0] b0,
        input logic [PAYLOAD_BITS-1:0] b1,
        input logic [PAYLOAD_BITS-1:0] b2
    );
        return DIVIDEND_W'(b0) * DIVIDEND_W'(1_000_000)
             + DIVIDEND_W'(b1) * DIVIDEND_W'(1_000)
             + DIVIDEND_W'(b2);
    endfunction

endpackage

// File: rtl/servo_frame_decoder_if.sv
// Byte-in / pulse-width-out bundle of the servo frame decoder.
//   i_rx_valid  - one-cycle strobe for a new received byte
//   i_rx_data   - received byte, meaningful only with i_rx_valid
//   o_pwm_width - pulse width in clock counts, held between updates
//   o_pwm_valid - one-cycle pulse when o_pwm_width changes
//   o_frame_err - one-cycle pulse on a discarded frame or byte
//   o_busy      - high while the division is running
// master: the byte source / PWM consumer side; slave: the decoder.
interface servo_frame_decoder_if;
    import servo_frame_decoder_pkg::*;

    logic                    i_rx_valid;
    logic [PAYLOAD_BITS-1:0] i_rx_data;
    logic [WIDTH_W-1:0]      o_pwm_width;
    logic                    o_pwm_valid;
    logic                    o_frame_err;
    logic                    o_busy;

    modport master (
        output i_rx_valid, i_rx_data,
        input  o_pwm_width, o_pwm_valid, o_frame_err, o_busy
    );

    modport slave (
        input  i_rx_valid, i_rx_data,
        output o_pwm_width, o_pwm_valid, o_frame_err, o_busy
    );

endinterface

// File: rtl/udiv_seq.sv
// Sequential restoring divider, one quotient bit per cycle, W iterations.
//   i_clk, i_resetn - clock, asynchronous active-low reset
//   start           - load dividend and begin (ignored bits of state are overwritten)
//   dividend        - numerator, sampled on start
//   divisor         - denominator, must be held stable while busy
//   busy            - high during the W iteration cycles
//   done            - one-cycle pulse, registered with the final iteration
//   quotient        - low QW bits of floor(dividend / divisor), valid with done
module udiv_seq
    import servo_frame_decoder_pkg::*;
#(
    parameter int unsigned W  = DIVIDEND_W,
    parameter int unsigned QW = WIDTH_W
) (
    input  logic          i_clk,
    input  logic          i_resetn,
    input  logic          start,
    input  logic [W-1:0]  dividend,
    input  logic [W-1:0]  divisor,
    output logic          busy,
    output logic          done,
    output logic [QW-1:0] quotient
);

    localparam int unsigned CntW = $clog2(W);

    logic [W-1:0]    rem_q, rem_d;
    // Dividend bits leave at the MSB while quotient bits enter at the LSB.
    logic [W-1:0]    quo_q, quo_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    logic [W:0]      shifted;
    logic [W:0]      sub;
    logic            fits;

    assign shifted = {rem_q, quo_q[W-1]};
    assign fits    = shifted >= {1'b0, divisor};
    assign sub     = shifted - {1'b0, divisor};

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        done_d = 1'b0;
        if (start) begin
            rem_d  = '0;
            quo_d  = dividend;
            cnt_d  = '0;
            busy_d = 1'b1;
        end else if (busy_q) begin
            if (fits) begin
                rem_d = sub[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = shifted[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntW'(W - 1)) begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            done_q <= done_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = quo_q[QW-1:0];

    // The remainder stays below the divisor, so sub[W] is always zero after a fit;
    // the upper quotient bits are zero for any dividend the decoder can produce.
    logic unused_bits;
    assign unused_bits = ^{quo_q[W-1:QW], sub[W]};

endmodule

// File: rtl/servo_frame_decoder.sv
// Decodes 3-byte servo frames (ms, us, ns digits) followed by a terminator into a
// PWM pulse width in clock counts: floor((b0*1e6 + b1*1e3 + b2) / CLK_PERIOD_NS).
//   i_clk    - system clock, rising edge
//   i_resetn - asynchronous active-low reset
//   bus      - slave side of servo_frame_decoder_if (byte strobe in, width out)
// Bytes arriving mid-calculation, bad terminators and inter-byte gaps of
// TIMEOUT_CYCLES inside a frame are discarded with an o_frame_err pulse.
module servo_frame_decoder
    import servo_frame_decoder_pkg::*;
#(
    parameter int unsigned             CLK_PERIOD_NS  = 37,
    parameter logic [PAYLOAD_BITS-1:0] TERMINATOR     = DEFAULT_TERMINATOR,
    parameter int unsigned             TIMEOUT_CYCLES = 27_000,
    parameter int unsigned             INIT_WIDTH     = 40_540
) (
    input  logic                 i_clk,
    input  logic                 i_resetn,
    servo_frame_decoder_if.slave bus
);

    localparam int unsigned TmrW = $clog2(TIMEOUT_CYCLES + 1);

    state_e                  state_q, state_d;
    logic [PAYLOAD_BITS-1:0] b0_q, b0_d;
    logic [PAYLOAD_BITS-1:0] b1_q, b1_d;
    logic [PAYLOAD_BITS-1:0] b2_q, b2_d;
    logic [TmrW-1:0]         timer_q, timer_d;
    logic [WIDTH_W-1:0]      width_q, width_d;
    logic                    pwm_valid_q, pwm_valid_d;
    logic                    frame_err_q, frame_err_d;

    logic                    div_start;
    logic                    div_busy;
    logic                    div_done;
    logic [WIDTH_W-1:0]      div_quotient;
    logic                    timeout_hit;

    assign timeout_hit = timer_q == TmrW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d     = state_q;
        b0_d        = b0_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        timer_d     = timer_q;
        width_d     = width_q;
        pwm_valid_d = 1'b0;
        frame_err_d = 1'b0;
        div_start   = 1'b0;

        unique case (state_q)
            StB0: begin
                timer_d = '0;
                if (bus.i_rx_valid) begin
                    b0_d    = bus.i_rx_data;
                    state_d = StB1;
                end
            end
            StB1, StB2, StTerm: begin
                if (bus.i_rx_valid) begin
                    timer_d = '0;
                    if (state_q == StB1) begin
                        b1_d    = bus.i_rx_data;
                        state_d = StB2;
                    end else if (state_q == StB2) begin
                        b2_d    = bus.i_rx_data;
                        state_d = StTerm;
                    end else if (bus.i_rx_data == TERMINATOR) begin
                        div_start = 1'b1;
                        state_d   = StCalc;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = StB0;
                    end
                end else if (timeout_hit) begin
                    timer_d     = '0;
                    frame_err_d = 1'b1;
                    state_d     = StB0;
                end else begin
                    timer_d = timer_q + TmrW'(1);
                end
            end
            StCalc: begin
                // A stray byte is dropped but never disturbs the running division.
                if (bus.i_rx_valid) begin
                    frame_err_d = 1'b1;
                end
                if (div_done) begin
                    width_d     = div_quotient;
                    pwm_valid_d = 1'b1;
                    state_d     = StB0;
                end
            end
            default: begin
                state_d = StB0;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            state_q     <= StB0;
            b0_q        <= '0;
            b1_q        <= '0;
            b2_q        <= '0;
            timer_q     <= '0;
            width_q     <= WIDTH_W'(INIT_WIDTH);
            pwm_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            b0_q        <= b0_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            timer_q     <= timer_d;
            width_q     <= width_d;
            pwm_valid_q <= pwm_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    udiv_seq #(
        .W  (DIVIDEND_W),
        .QW (WIDTH_W)
    ) u_div (
        .i_clk    (i_clk),
        .i_resetn (i_resetn),
        .start    (div_start),
        .dividend (calc_dividend(b0_q, b1_q, b2_q)),
        .divisor  (DIVIDEND_W'(CLK_PERIOD_NS)),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_quotient)
    );

    assign bus.o_pwm_width = width_q;
    assign bus.o_pwm_valid = pwm_valid_q;
    assign bus.o_frame_err = frame_err_q;
    assign bus.o_busy      = state_q == StCalc;

    // The FSM state already tracks the division window.
    logic unused_div_busy;
    assign unused_div_busy = div_busy;

endmodule

// File: tb/tb_servo_frame_decoder.sv
module tb_servo_frame_decoder;
    import servo_frame_decoder_pkg::*;

    localparam int unsigned TIMEOUT = 27_000;
    localparam int unsigned INIT_W  = 40_540;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   valid_cnt = 0;
    int   err_cnt   = 0;

    servo_frame_decoder_if bus ();

    servo_frame_decoder #(
        .CLK_PERIOD_NS  (37),
        .TERMINATOR     (8'h0A),
        .TIMEOUT_CYCLES (TIMEOUT),
        .INIT_WIDTH     (INIT_W)
    ) dut (
        .i_clk    (clk),
        .i_resetn (rst_n),
        .bus      (bus)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.o_pwm_valid === 1'b1) valid_cnt++;
        if (bus.o_frame_err === 1'b1) err_cnt++;
    end

    // Strobe one byte; returns at the falling edge after the accepting rising edge.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        bus.i_rx_valid = 1'b1;
        bus.i_rx_data  = b;
        @(negedge clk);
        bus.i_rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                              input logic [7:0] b2, input logic [7:0] t);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(t);
    endtask

    // Cycles from the terminator edge until o_pwm_valid is seen, -1 if never.
    task automatic wait_pwm(output int lat);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (bus.o_pwm_valid === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.i_rx_valid = 1'b0;
        bus.i_rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.o_pwm_width !== 23'(INIT_W)) begin
            n_fail++; $display("FAIL reset_width actual=%0d required=%0d", bus.o_pwm_width, INIT_W);
        end
        n_checks++;
        if (bus.o_pwm_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid actual=%b required=0", bus.o_pwm_valid);
        end
        n_checks++;
        if (bus.o_frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_err actual=%b required=0", bus.o_frame_err);
        end
        n_checks++;
        if (bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL reset_busy actual=%b required=0", bus.o_busy);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bad_term();
        int v0, e0, lat;
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'd1, 8'd2, 8'd3, 8'h0D);
        n_checks++;
        if (bus.o_frame_err !== 1'b1) begin
            n_fail++; $display("FAIL bad_term_err actual=%b required=1", bus.o_frame_err);
        end
        repeat (5) @(negedge clk);
        n_checks++;
        if (err_cnt - e0 !== 1) begin
            n_fail++; $display("FAIL bad_term_err_pulses actual=%0d required=1", err_cnt - e0);
        end
        n_checks++;
        if (valid_cnt - v0 !== 0) begin
            n_fail++; $display("FAIL bad_term_valid_pulses actual=%0d required=0", valid_cnt - v0);
        end
        n_checks++;
        if (bus.o_pwm_width !== 23'(INIT_W)) begin
            n_fail++; $display("FAIL bad_term_width actual=%0d required=%0d", bus.o_pwm_width, INIT_W);
        end
        send_frame(8'd1, 8'd2, 8'd3, 8'h0A);
        wait_pwm(lat);
        n_checks++;
        if (bus.o_pwm_width !== 23'd27_081) begin
            n_fail++; $display("FAIL bad_term_recover actual=%0d required=27081", bus.o_pwm_width);
        end
    endtask

    task automatic test_basic();
        int lat;
        send_frame(8'd1, 8'd2, 8'd3, 8'h0A);
        n_checks++;
        if (bus.o_busy !== 1'b1) begin
            n_fail++; $display("FAIL basic_busy actual=%b required=1", bus.o_busy);
        end
        wait_pwm(lat);
        n_checks++;
        if (lat !== 29) begin
            n_fail++; $display("FAIL basic_latency actual=%0d required=29", lat);
        end
        n_checks++;
        if (bus.o_pwm_width !== 23'd27_081) begin
            n_fail++; $display("FAIL basic_width actual=%0d required=27081", bus.o_pwm_width);
        end
        @(negedge clk);
        n_checks++;
        if (bus.o_pwm_valid !== 1'b0 || bus.o_busy !== 1'b0) begin
            n_fail++; $display("FAIL basic_after actual=valid%b/busy%b required=0/0",
                               bus.o_pwm_valid, bus.o_busy);
        end
    endtask

    task automatic test_values();
        logic [7:0]  vb [3][3];
        logic [22:0] vexp [3];
        int lat;
        vb[0] = '{8'd20, 8'd0, 8'd0};       vexp[0] = 23'd540_540;
        vb[1] = '{8'd255, 8'd255, 8'd255};  vexp[1] = 23'd6_898_790;
        vb[2] = '{8'h0A, 8'h0A, 8'h0A};     vexp[2] = 23'd270_540;  // terminator as data
        for (int i = 0; i < 3; i++) begin
            send_frame(vb[i][0], vb[i][1], vb[i][2], 8'h0A);
            wait_pwm(lat);
            n_checks++;
            if (lat !== 29 || bus.o_pwm_width !== vexp[i]) begin
                n_fail++; $display("FAIL values_%0d actual=%0d lat=%0d required=%0d lat=29",
                                   i, bus.o_pwm_width, lat, vexp[i]);
            end
        end
    endtask

    task automatic test_timeout();
        int k_err, lat;
        send_byte(8'd1);
        send_byte(8'd2);
        k_err = -1;
        for (int k = 1; k <= int'(TIMEOUT) + 100; k++) begin
            @(negedge clk);
            if (bus.o_frame_err === 1'b1) begin
                k_err = k;
                break;
            end
        end
        n_checks++;
        if (k_err !== int'(TIMEOUT)) begin
            n_fail++; $display("FAIL timeout_cycles actual=%0d required=%0d", k_err, TIMEOUT);
        end
        send_frame(8'd20, 8'd0, 8'd0, 8'h0A);
        wait_pwm(lat);
        n_checks++;
        if (lat !== 29 || bus.o_pwm_width !== 23'd540_540) begin
            n_fail++; $display("FAIL timeout_recover actual=%0d lat=%0d required=540540 lat=29",
                               bus.o_pwm_width, lat);
        end
    endtask

    task automatic test_extra_byte();
        int lat;
        lat = -1;
        send_frame(8'd1, 8'd2, 8'd3, 8'h0A);
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 9) begin
                bus.i_rx_valid = 1'b1;
                bus.i_rx_data  = 8'h55;
            end
            if (k == 10) begin
                bus.i_rx_valid = 1'b0;
                n_checks++;
                if (bus.o_frame_err !== 1'b1 || bus.o_busy !== 1'b1) begin
                    n_fail++; $display("FAIL extra_err_busy actual=err%b/busy%b required=1/1",
                                       bus.o_frame_err, bus.o_busy);
                end
            end
            if (bus.o_pwm_valid === 1'b1 && lat < 0) lat = k;
        end
        n_checks++;
        if (lat !== 29 || bus.o_pwm_width !== 23'd27_081) begin
            n_fail++; $display("FAIL extra_result actual=%0d lat=%0d required=27081 lat=29",
                               bus.o_pwm_width, lat);
        end
    endtask

    task automatic test_coincide();
        send_frame(8'd20, 8'd0, 8'd0, 8'h0A);
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            if (k == 28) begin
                bus.i_rx_valid = 1'b1;
                bus.i_rx_data  = 8'h33;
            end
        end
        bus.i_rx_valid = 1'b0;
        n_checks++;
        if (bus.o_pwm_valid !== 1'b1 || bus.o_frame_err !== 1'b1) begin
            n_fail++; $display("FAIL coincide actual=valid%b/err%b required=1/1",
                               bus.o_pwm_valid, bus.o_frame_err);
        end
        n_checks++;
        if (bus.o_pwm_width !== 23'd540_540) begin
            n_fail++; $display("FAIL coincide_width actual=%0d required=540540", bus.o_pwm_width);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset_calc();
        int v0, lat;
        send_frame(8'd1, 8'd2, 8'd3, 8'h0A);
        repeat (15) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.o_pwm_width !== 23'(INIT_W) || bus.o_busy !== 1'b0 ||
            bus.o_pwm_valid !== 1'b0 || bus.o_frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_calc actual=%0d/busy%b/valid%b/err%b required=%0d/0/0/0",
                               bus.o_pwm_width, bus.o_busy, bus.o_pwm_valid, bus.o_frame_err,
                               INIT_W);
        end
        v0 = valid_cnt;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        n_checks++;
        if (valid_cnt - v0 !== 0) begin
            n_fail++; $display("FAIL reset_calc_no_valid actual=%0d required=0", valid_cnt - v0);
        end
        send_frame(8'd255, 8'd255, 8'd255, 8'h0A);
        wait_pwm(lat);
        n_checks++;
        if (lat !== 29 || bus.o_pwm_width !== 23'd6_898_790) begin
            n_fail++; $display("FAIL reset_calc_recover actual=%0d lat=%0d required=6898790 lat=29",
                               bus.o_pwm_width, lat);
        end
    endtask

    initial begin
        test_reset();
        test_bad_term();
        test_basic();
        test_values();
        test_timeout();
        test_extra_byte();
        test_coincide();
        test_reset_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
